// File: rtl/seq_flash_player.sv
// Sequence flash player: replays a stored colour sequence as timed
// one-hot LED flashes with blank gaps, and echoes buttons while idle.
module seq_flash_player #(
    parameter  int NUM_COLOURS = 4,
    parameter  int MAX_LEN     = 32,
    parameter  int ON_TICKS    = 4,
    parameter  int OFF_TICKS   = 2,
    localparam int CODE_W      = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1,
    localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                        flash_clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [LEN_W-1:0]            seq_len,
    input  logic [MAX_LEN*CODE_W-1:0]   segment,
    input  logic [NUM_COLOURS-1:0]      player_input,
    output logic [NUM_COLOURS-1:0]      disp,
    output logic                        busy,
    output logic                        done,
    output logic [LEN_W-1:0]            step_idx
);

    localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LAST =
        (OFF_TICKS > 0) ? TICK_W'(OFF_TICKS - 1) : '0;
    localparam logic [LEN_W-1:0]  LEN_CAP  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP,
        S_FIN
    } state_t;

    state_t                   state_q;
    logic [NUM_COLOURS-1:0]   disp_q;
    logic                     busy_q;
    logic                     done_q;
    logic [LEN_W-1:0]         step_q;
    logic [TICK_W-1:0]        tick_q;
    logic [LEN_W-1:0]         len_q;

    logic [LEN_W-1:0]         len_d;
    logic                     last_step;
    int unsigned              nxt_base;
    logic [CODE_W-1:0]        first_code;
    logic [CODE_W-1:0]        next_code;

    // Codes of out-of-range colours map to an all-dark LED pattern.
    function automatic logic [NUM_COLOURS-1:0] onehot(
        input logic [CODE_W-1:0] c
    );
        logic [NUM_COLOURS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_COLOURS; k++) begin
            if (c == CODE_W'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    assign len_d      = (seq_len > LEN_CAP) ? LEN_CAP : seq_len;
    assign last_step  = ((step_q + LEN_W'(1)) == len_q);
    assign nxt_base   = (32'(step_q) + 32'd1) * CODE_W;
    assign first_code = segment[CODE_W-1:0];
    assign next_code  = segment[nxt_base +: CODE_W];

    // Playback FSM; every output is a register updated here.
    always_ff @(posedge flash_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
            tick_q  <= '0;
            len_q   <= '0;
        end else if (abort && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
            tick_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    disp_q <= player_input;
                    if (start) begin
                        len_q  <= len_d;
                        step_q <= '0;
                        tick_q <= '0;
                        busy_q <= 1'b1;
                        if (len_d == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            disp_q  <= '0;
                        end else begin
                            state_q <= S_ON;
                            disp_q  <= onehot(first_code);
                        end
                    end
                end
                S_ON: begin
                    if (tick_q == ON_LAST) begin
                        tick_q <= '0;
                        if (OFF_TICKS > 0) begin
                            state_q <= S_GAP;
                            disp_q  <= '0;
                        end else if (last_step) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            disp_q  <= '0;
                        end else begin
                            step_q <= step_q + LEN_W'(1);
                            disp_q <= onehot(next_code);
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                S_GAP: begin
                    disp_q <= '0;
                    if (tick_q == OFF_LAST) begin
                        tick_q <= '0;
                        if (last_step) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ON;
                            step_q  <= step_q + LEN_W'(1);
                            disp_q  <= onehot(next_code);
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    step_q  <= '0;
                    disp_q  <= '0;
                end
            endcase
        end
    end

    assign disp     = disp_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_q;

endmodule
